// File: rtl/seqgen_pkg.sv
// Shared definitions for the serial sequence generator: state encodings
// (which double as the Q LED display code) and the factory default pattern.
package seqgen_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_SHIFT = 3'b001,
        S_PAR   = 3'b010,
        S_GAP   = 3'b011,
        S_DONE  = 3'b100
    } state_t;

    localparam logic [5:0] DEFAULT_PATTERN = 6'b010110;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register. Load has priority over shift and
// the MSB is presented as the serial output. Synchronous active-low reset.
module piso_shift_reg #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr;

    // Hold, load a new word, or move everything one place toward the MSB
    always_ff @(posedge clock) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first on X
// for a programmable number of frames separated by idle gaps.
// Optional feature macro: PARITY_EN adds an even-parity bit (state PAR)
// after each frame; without it frames are exactly PAT_W bits.
// The shift register is loaded with the pattern already shifted by one,
// because the MSB goes straight into the X register on the entry edge and
// the shift register then supplies the following bit on every later edge.
module sequence_generator
    import seqgen_pkg::*;
#(
    parameter int               PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
    parameter int               CNT_W   = 4,
    parameter int               GAP     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             use_default,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             X,
    output logic             valid,
    output logic             busy,
    output logic             frame_end,
    output logic             done,
    output logic [2:0]       Q
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
    localparam logic [BIT_W-1:0] PREV_BIT = BIT_W'(PAT_W - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
`ifdef PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    state_t           state;
    logic [PAT_W-1:0] pat_lat;
    logic [CNT_W-1:0] rep_lat;
    logic [CNT_W-1:0] frame_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             stop_lat;

    logic [PAT_W-1:0] sel_pat;
    logic [PAT_W-1:0] piso_din;
    logic [CNT_W-1:0] frame_next;
    logic             piso_load;
    logic             piso_shift;
    logic             piso_msb;
    logic             stop_seen;
    logic             last_cycle;
    logic             end_run;

    piso_shift_reg #(.W(PAT_W)) u_piso (
        .clock (clock),
        .reset (reset),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (piso_din),
        .msb   (piso_msb)
    );

    // Frame-boundary decisions and shift register control
    always_comb begin
        sel_pat    = use_default ? PATTERN : pat_in;
        stop_seen  = stop_lat | stop;
        frame_next = frame_cnt + 1'b1;
`ifdef PARITY_EN
        last_cycle = (state == S_PAR);
`else
        last_cycle = (state == S_SHIFT) && (bit_cnt == LAST_BIT);
`endif
        end_run    = last_cycle &&
                     (stop_seen || ((rep_lat != '0) && (frame_next == rep_lat)));
        piso_load  = ((state == S_IDLE) && start) || (last_cycle && !end_run);
        piso_din   = (state == S_IDLE) ? {sel_pat[PAT_W-2:0], 1'b0}
                                       : {pat_lat[PAT_W-2:0], 1'b0};
        piso_shift = (state == S_SHIFT);
    end

    // Main FSM with counters, stop latch and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            pat_lat   <= '0;
            rep_lat   <= '0;
            frame_cnt <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            stop_lat  <= 1'b0;
            X         <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_end <= 1'b0;
            done      <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            done      <= 1'b0;
            if (state != S_IDLE) begin
                stop_lat <= stop_lat | stop;
            end
            if (last_cycle) begin
                frame_cnt <= frame_next;
                bit_cnt   <= '0;
                gap_cnt   <= '0;
                X         <= 1'b0;
                valid     <= 1'b0;
                if (end_run) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else begin
                    state <= S_GAP;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state     <= S_SHIFT;
                            pat_lat   <= sel_pat;
                            rep_lat   <= repeat_n;
                            stop_lat  <= 1'b0;
                            frame_cnt <= '0;
                            bit_cnt   <= '0;
                            gap_cnt   <= '0;
                            X         <= sel_pat[PAT_W-1];
                            valid     <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    S_SHIFT: begin
`ifdef PARITY_EN
                        if (bit_cnt == LAST_BIT) begin
                            state     <= S_PAR;
                            X         <= ^pat_lat;
                            frame_end <= 1'b1;
                        end else
`endif
                        begin
                            X         <= piso_msb;
                            bit_cnt   <= bit_cnt + 1'b1;
                            frame_end <= !PARITY_ON && (bit_cnt == PREV_BIT);
                        end
                    end
                    S_GAP: begin
                        if (stop_seen) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (gap_cnt == GAP_LAST) begin
                            state   <= S_SHIFT;
                            bit_cnt <= '0;
                            X       <= pat_lat[PAT_W-1];
                            valid   <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        X     <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Q = state;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed testbench for sequence_generator. Builds with or without
// PARITY_EN; the expected frame contents switch with the macro.
module tb_sequence_generator;

`ifdef PARITY_EN
    localparam int FLEN = 7;
    localparam logic [FLEN-1:0] FRAME_DEF = 7'b0101101;
    localparam logic [FLEN-1:0] FRAME_USR = 7'b1110001;
    localparam bit PAR_ON = 1'b1;
`else
    localparam int FLEN = 6;
    localparam logic [FLEN-1:0] FRAME_DEF = 6'b010110;
    localparam logic [FLEN-1:0] FRAME_USR = 6'b111000;
    localparam bit PAR_ON = 1'b0;
`endif
    localparam logic [7:0] EXP_GAP  = 8'b0010_0011;
    localparam logic [7:0] EXP_DONE = 8'b0010_1100;
    localparam logic [7:0] EXP_IDLE = 8'b0000_0000;

    logic       clock;
    logic       reset;
    logic       start;
    logic       stop;
    logic       use_default;
    logic [5:0] pat_in;
    logic [3:0] repeat_n;
    logic       X;
    logic       valid;
    logic       busy;
    logic       frame_end;
    logic       done;
    logic [2:0] Q;

    int tests_run    = 0;
    int tests_failed = 0;

    sequence_generator dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .use_default (use_default),
        .pat_in      (pat_in),
        .repeat_n    (repeat_n),
        .X           (X),
        .valid       (valid),
        .busy        (busy),
        .frame_end   (frame_end),
        .done        (done),
        .Q           (Q)
    );

    // Free-running 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net in case the run never reaches its summary
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] observed();
        return {X, valid, busy, frame_end, done, Q};
    endfunction

    // Expected output vector for bit i of a frame
    function automatic logic [7:0] bit_vec(input logic [FLEN-1:0] frame, input int i);
        logic last;
        logic [2:0] q;
        last = (i == FLEN - 1);
        q = (PAR_ON && last) ? 3'b010 : 3'b001;
        return {frame[FLEN-1-i], 1'b1, 1'b1, last, 1'b0, q};
    endfunction

    task automatic step();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic s, input logic sp, input logic ud,
                                 input logic [5:0] p, input logic [3:0] r);
        start       = s;
        stop        = sp;
        use_default = ud;
        pat_in      = p;
        repeat_n    = r;
    endtask

    // Reset state: every output low, Q = IDLE
    task automatic test_reset();
        reset = 1'b0;
        applyStimulus(0, 0, 1, 6'b0, 4'd0);
        step();
        step();
        tests_run++;
        if (observed() !== EXP_IDLE) begin
            tests_failed++;
            $display("[TB] FAIL reset_state got %b want %b", observed(), EXP_IDLE);
        end
        reset = 1'b1;
        step();
    endtask

    // Single frame of the default pattern, then DONE and IDLE
    task automatic test_default_single();
        applyStimulus(1, 0, 1, 6'b0, 4'd1);
        step();
        start = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            tests_run++;
            if (observed() !== bit_vec(FRAME_DEF, i)) begin
                tests_failed++;
                $display("[TB] FAIL single_bit%0d got %b want %b", i, observed(), bit_vec(FRAME_DEF, i));
            end
            step();
        end
        tests_run++;
        if (observed() !== EXP_DONE) begin
            tests_failed++;
            $display("[TB] FAIL single_done got %b want %b", observed(), EXP_DONE);
        end
        step();
        tests_run++;
        if (observed() !== EXP_IDLE) begin
            tests_failed++;
            $display("[TB] FAIL single_idle got %b want %b", observed(), EXP_IDLE);
        end
    endtask

    // Three frames of a user pattern with gaps between them only
    task automatic test_repeat_user();
        int fe_seen = 0;
        int done_seen = 0;
        applyStimulus(1, 0, 0, 6'b111000, 4'd3);
        step();
        start = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FLEN; i++) begin
                tests_run++;
                if (observed() !== bit_vec(FRAME_USR, i)) begin
                    tests_failed++;
                    $display("[TB] FAIL repeat_f%0d_bit%0d got %b want %b", f, i, observed(), bit_vec(FRAME_USR, i));
                end
                if (frame_end) fe_seen++;
                if (done) done_seen++;
                step();
            end
            if (f < 2) begin
                for (int g = 0; g < 2; g++) begin
                    tests_run++;
                    if (observed() !== EXP_GAP) begin
                        tests_failed++;
                        $display("[TB] FAIL repeat_gap%0d_%0d got %b want %b", f, g, observed(), EXP_GAP);
                    end
                    step();
                end
            end
        end
        if (done) done_seen++;
        tests_run++;
        if (observed() !== EXP_DONE) begin
            tests_failed++;
            $display("[TB] FAIL repeat_done got %b want %b", observed(), EXP_DONE);
        end
        step();
        tests_run++;
        if (fe_seen != 3 || done_seen != 1) begin
            tests_failed++;
            $display("[TB] FAIL repeat_pulses got fe=%0d done=%0d want fe=3 done=1", fe_seen, done_seen);
        end
        tests_run++;
        if (observed() !== EXP_IDLE) begin
            tests_failed++;
            $display("[TB] FAIL repeat_idle got %b want %b", observed(), EXP_IDLE);
        end
    endtask

    // Continuous mode, stop pulsed inside frame 4: frame 4 finishes, then DONE
    task automatic test_stop_continuous();
        applyStimulus(1, 0, 1, 6'b0, 4'd0);
        step();
        start = 1'b0;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < FLEN; i++) begin
                tests_run++;
                if (observed() !== bit_vec(FRAME_DEF, i)) begin
                    tests_failed++;
                    $display("[TB] FAIL stop_f%0d_bit%0d got %b want %b", f, i, observed(), bit_vec(FRAME_DEF, i));
                end
                stop = (f == 3 && i == 2);
                step();
            end
            stop = 1'b0;
            if (f < 3) begin
                step();
                step();
            end
        end
        tests_run++;
        if (observed() !== EXP_DONE) begin
            tests_failed++;
            $display("[TB] FAIL stop_done got %b want %b", observed(), EXP_DONE);
        end
        step();
        tests_run++;
        if (observed() !== EXP_IDLE) begin
            tests_failed++;
            $display("[TB] FAIL stop_idle got %b want %b", observed(), EXP_IDLE);
        end
    endtask

    // Stop raised in a gap ends the run on the next edge with no new frame
    task automatic test_stop_gap();
        applyStimulus(1, 0, 0, 6'b111000, 4'd0);
        step();
        start = 1'b0;
        for (int i = 0; i < FLEN; i++) step();
        tests_run++;
        if (observed() !== EXP_GAP) begin
            tests_failed++;
            $display("[TB] FAIL gapstop_gap got %b want %b", observed(), EXP_GAP);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        tests_run++;
        if (observed() !== EXP_DONE) begin
            tests_failed++;
            $display("[TB] FAIL gapstop_done got %b want %b", observed(), EXP_DONE);
        end
        step();
        tests_run++;
        if (observed() !== EXP_IDLE) begin
            tests_failed++;
            $display("[TB] FAIL gapstop_idle got %b want %b", observed(), EXP_IDLE);
        end
    endtask

    // Reset in mid-frame aborts at once; start is ignored while reset is held
    task automatic test_reset_midframe();
        applyStimulus(1, 0, 1, 6'b0, 4'd0);
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (observed() !== bit_vec(FRAME_DEF, 3)) begin
            tests_failed++;
            $display("[TB] FAIL midreset_bit3 got %b want %b", observed(), bit_vec(FRAME_DEF, 3));
        end
        reset = 1'b0;
        start = 1'b1;
        step();
        tests_run++;
        if (observed() !== EXP_IDLE) begin
            tests_failed++;
            $display("[TB] FAIL midreset_abort got %b want %b", observed(), EXP_IDLE);
        end
        step();
        tests_run++;
        if (observed() !== EXP_IDLE) begin
            tests_failed++;
            $display("[TB] FAIL midreset_hold got %b want %b", observed(), EXP_IDLE);
        end
        reset = 1'b1;
        start = 1'b0;
        step();
        tests_run++;
        if (observed() !== EXP_IDLE) begin
            tests_failed++;
            $display("[TB] FAIL midreset_release got %b want %b", observed(), EXP_IDLE);
        end
    endtask

    // Start held high: no restart until IDLE, then a new run the cycle after
    task automatic test_back_to_back();
        applyStimulus(1, 0, 1, 6'b0, 4'd1);
        step();
        for (int i = 0; i < FLEN; i++) begin
            tests_run++;
            if (observed() !== bit_vec(FRAME_DEF, i)) begin
                tests_failed++;
                $display("[TB] FAIL held_bit%0d got %b want %b", i, observed(), bit_vec(FRAME_DEF, i));
            end
            step();
        end
        tests_run++;
        if (observed() !== EXP_DONE) begin
            tests_failed++;
            $display("[TB] FAIL held_done got %b want %b", observed(), EXP_DONE);
        end
        step();
        tests_run++;
        if (observed() !== EXP_IDLE) begin
            tests_failed++;
            $display("[TB] FAIL held_idle got %b want %b", observed(), EXP_IDLE);
        end
        step();
        start = 1'b0;
        tests_run++;
        if (observed() !== bit_vec(FRAME_DEF, 0)) begin
            tests_failed++;
            $display("[TB] FAIL held_restart got %b want %b", observed(), bit_vec(FRAME_DEF, 0));
        end
        for (int k = 0; k < 40 && busy !== 1'b0; k++) step();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL held_drain got busy=%b want busy=0", busy);
        end
    endtask

    // Scenario sequence and summary
    initial begin
        reset = 1'b0;
        applyStimulus(0, 0, 1, 6'b0, 4'd0);
        test_reset();
        test_default_single();
        test_repeat_user();
        test_stop_continuous();
        test_stop_gap();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
